// File: rtl/retire_rat.sv
// Retirement register alias table: holds the committed arch->phys map, frees the
// displaced physical register on each commit, and replays the map to rename on flush.
module retire_rat #(
  parameter int ARCH_REGS = 32,
  parameter int PHYS_REGS = 64,
  parameter int ARCH_W    = $clog2(ARCH_REGS),
  parameter int PHYS_W    = $clog2(PHYS_REGS)
) (
  input  logic                        CLK,
  input  logic                        RESET,
  input  logic                        newMap_flag_rrat,
  input  logic [ARCH_W-1:0]           reg2map_rrat,
  input  logic [PHYS_W-1:0]           newMap_rrat,
  input  logic                        flush,
  output logic                        free_valid,
  output logic [PHYS_W-1:0]           free_reg,
  output logic                        recovery_busy,
  output logic                        restore_valid,
  output logic [ARCH_W-1:0]           restore_arch,
  output logic [PHYS_W-1:0]           restore_phys,
  output logic [ARCH_REGS*PHYS_W-1:0] rrat_map
);

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_e;

  localparam logic [ARCH_W-1:0] LAST_IDX = ARCH_W'(ARCH_REGS - 1);

  logic [PHYS_W-1:0] map_q [ARCH_REGS];
  logic [PHYS_W-1:0] map_d [ARCH_REGS];
  logic [PHYS_W-1:0] commit_free;

  state_e            state_q, state_d;
  logic [ARCH_W-1:0] idx_q, idx_d;
  logic [PHYS_W-1:0] restore_phys_q, restore_phys_d;
  logic              free_valid_q;
  logic [PHYS_W-1:0] free_reg_q;
  logic              restart;

  // Commit view of the map; $zero is never remapped, so its commit frees newMap itself.
  always_comb begin
    map_d = map_q;
    if (newMap_flag_rrat && (reg2map_rrat != '0)) begin
      map_d[reg2map_rrat] = newMap_rrat;
    end
    commit_free = (reg2map_rrat == '0) ? newMap_rrat : map_q[reg2map_rrat];
  end

  // A commit during the walk changes the map rename is rebuilding, so replay from entry 0.
  assign restart = flush || (newMap_flag_rrat && (state_q == RESTORE));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    idx_d   = idx_q;
    if (restart) begin
      state_d = RESTORE;
      idx_d   = '0;
    end else if (state_q == RESTORE) begin
      if (idx_q == LAST_IDX) begin
        state_d = IDLE;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    restore_phys_d = (state_d == RESTORE) ? map_d[idx_d] : '0;
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      // NOTE: the map is a small flop array that must come up as the identity map,
      // so it is reset explicitly rather than left to a RAM macro.
      for (int i = 0; i < ARCH_REGS; i++) begin
        map_q[i] <= PHYS_W'(i);
      end
      state_q        <= IDLE;
      idx_q          <= '0;
      restore_phys_q <= '0;
      free_valid_q   <= 1'b0;
      free_reg_q     <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples pre-edge values.
      map_q          <= map_d;
      state_q        <= state_d;
      idx_q          <= idx_d;
      restore_phys_q <= restore_phys_d;
      free_valid_q   <= newMap_flag_rrat;
      if (newMap_flag_rrat) begin
        free_reg_q <= commit_free;
      end
    end
  end

  assign free_valid    = free_valid_q;
  assign free_reg      = free_reg_q;
  assign restore_valid = (state_q == RESTORE);
  assign recovery_busy = (state_q == RESTORE);
  assign restore_arch  = idx_q;
  assign restore_phys  = restore_phys_q;

  for (genvar g = 0; g < ARCH_REGS; g++) begin : g_flat
    assign rrat_map[g*PHYS_W +: PHYS_W] = map_q[g];
  end

endmodule

// File: tb/tb_retire_rat.sv
// Self-checking bench for retire_rat: directed scenarios plus randomized commits and
// flushes scored against a queue-based model of the committed map and restore walk.
module tb_retire_rat;

  localparam int ARCH_REGS = 32;
  localparam int PHYS_REGS = 64;
  localparam int ARCH_W    = 5;
  localparam int PHYS_W    = 6;

  logic                        CLK = 1'b0;
  logic                        RESET;
  logic                        newMap_flag_rrat;
  logic [ARCH_W-1:0]           reg2map_rrat;
  logic [PHYS_W-1:0]           newMap_rrat;
  logic                        flush;
  logic                        free_valid;
  logic [PHYS_W-1:0]           free_reg;
  logic                        recovery_busy;
  logic                        restore_valid;
  logic [ARCH_W-1:0]           restore_arch;
  logic [PHYS_W-1:0]           restore_phys;
  logic [ARCH_REGS*PHYS_W-1:0] rrat_map;

  retire_rat #(
    .ARCH_REGS(ARCH_REGS),
    .PHYS_REGS(PHYS_REGS)
  ) dut (
    .CLK             (CLK),
    .RESET           (RESET),
    .newMap_flag_rrat(newMap_flag_rrat),
    .reg2map_rrat    (reg2map_rrat),
    .newMap_rrat     (newMap_rrat),
    .flush           (flush),
    .free_valid      (free_valid),
    .free_reg        (free_reg),
    .recovery_busy   (recovery_busy),
    .restore_valid   (restore_valid),
    .restore_arch    (restore_arch),
    .restore_phys    (restore_phys),
    .rrat_map        (rrat_map)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int arch;
    int phys;
  } beat_t;

  int    checks   = 0;
  int    failures = 0;
  int    busy_cnt = 0;
  int    mmap [ARCH_REGS];
  beat_t beats [$];
  bit    exp_fv;
  int    exp_fr;
  bit    exp_rv;
  int    exp_ra;
  int    exp_rp;

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < ARCH_REGS; i++) mmap[i] = i;
    beats.delete();
    exp_fv = 1'b0;
    exp_fr = 0;
    exp_rv = 1'b0;
    exp_ra = 0;
    exp_rp = 0;
  endtask

  function automatic logic [255:0] flat_map();
    logic [255:0] v = '0;
    for (int i = 0; i < ARCH_REGS; i++) v[i*PHYS_W +: PHYS_W] = PHYS_W'(mmap[i]);
    return v;
  endfunction

  // Effect of one rising edge: commit first, then (re)start or advance the walk.
  task automatic model_step(input bit f, input int r, input int nm, input bit fl);
    bit    walking = exp_rv;
    beat_t b;
    if (f) begin
      exp_fv = 1'b1;
      if (r == 0) begin
        exp_fr = nm;
      end else begin
        exp_fr  = mmap[r];
        mmap[r] = nm;
      end
    end else begin
      exp_fv = 1'b0;
    end
    if (fl || (f && walking)) begin
      beats.delete();
      for (int i = 0; i < ARCH_REGS; i++) beats.push_back('{i, mmap[i]});
    end
    if (beats.size() > 0) begin
      b      = beats.pop_front();
      exp_rv = 1'b1;
      exp_ra = b.arch;
      exp_rp = b.phys;
    end else begin
      exp_rv = 1'b0;
    end
  endtask

  task automatic compare_all();
    check("free_valid", 256'(free_valid), 256'(exp_fv));
    check("free_reg", 256'(free_reg), 256'(exp_fr));
    check("restore_valid", 256'(restore_valid), 256'(exp_rv));
    check("recovery_busy", 256'(recovery_busy), 256'(exp_rv));
    if (exp_rv) begin
      check("restore_arch", 256'(restore_arch), 256'(exp_ra));
      check("restore_phys", 256'(restore_phys), 256'(exp_rp));
    end
    check("rrat_map", 256'(rrat_map), flat_map());
    if (recovery_busy) busy_cnt++;
  endtask

  task automatic cycle(input bit f, input int r, input int nm, input bit fl);
    @(negedge CLK);
    newMap_flag_rrat = f;
    reg2map_rrat     = ARCH_W'(r);
    newMap_rrat      = PHYS_W'(nm);
    flush            = fl;
    model_step(f, r, nm, fl);
    @(posedge CLK);
    #1;
    compare_all();
  endtask

  initial begin
    RESET            = 1'b0;
    newMap_flag_rrat = 1'b0;
    reg2map_rrat     = '0;
    newMap_rrat      = '0;
    flush            = 1'b0;
    model_reset();
    repeat (3) @(negedge CLK);
    RESET = 1'b1;
    #1;
    compare_all();
    cycle(0, 0, 0, 0);

    // Chained commits to the same register, then a $zero commit.
    cycle(1, 5, 40, 0);
    check("free_after_5_40", 256'(free_reg), 256'(5));
    cycle(1, 5, 41, 0);
    check("free_after_5_41", 256'(free_reg), 256'(40));
    cycle(1, 0, 33, 0);
    check("free_after_0_33", 256'(free_reg), 256'(33));
    cycle(0, 0, 0, 0);

    // Commit and flush at the same edge: beat 7 carries the new mapping.
    busy_cnt = 0;
    cycle(1, 7, 50, 1);
    for (int i = 0; i < 33; i++) begin
      if (restore_valid && (restore_arch == 5'd7)) check("beat7_phys", 256'(restore_phys), 256'(50));
      cycle(0, 0, 0, 0);
    end
    check("busy_len_single", 256'(busy_cnt), 256'(32));

    // Second flush while beat 11 is showing: 0..11 then 0..31.
    busy_cnt = 0;
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 11; i++) cycle(0, 0, 0, 0);
    check("arch_before_reflush", 256'(restore_arch), 256'(11));
    cycle(0, 0, 0, 1);
    check("arch_after_reflush", 256'(restore_arch), 256'(0));
    for (int i = 0; i < 33; i++) cycle(0, 0, 0, 0);
    check("busy_len_reflush", 256'(busy_cnt), 256'(44));

    // Asynchronous reset in the middle of a walk.
    cycle(0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 0);
    check("arch_before_reset", 256'(restore_arch), 256'(20));
    #2;
    RESET = 1'b0;
    #1;
    model_reset();
    check("rst_restore_valid", 256'(restore_valid), 256'(0));
    check("rst_recovery_busy", 256'(recovery_busy), 256'(0));
    check("rst_restore_arch", 256'(restore_arch), 256'(0));
    check("rst_rrat_map", 256'(rrat_map), flat_map());
    repeat (2) @(negedge CLK);
    RESET = 1'b1;
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0);

    // Randomized commits and flushes; commits are rare while a walk is running.
    for (int n = 0; n < 3000; n++) begin
      bit f;
      bit fl;
      int r;
      int nm;
      if (exp_rv) f = ($urandom_range(0, 19) == 0);
      else        f = ($urandom_range(0, 1) == 1);
      r  = int'($urandom_range(0, ARCH_REGS - 1));
      nm = int'($urandom_range(0, PHYS_REGS - 1));
      fl = ($urandom_range(0, 39) == 0);
      cycle(f, r, nm, fl);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
